mem_arbiter: RTL and testbench

- Shares the single byte-wide RAM/IO port between the instruction fetcher (IF) and the load/store buffer (LSB).
- Splits each 1/2/4-byte access into sequential byte transfers and assembles read data little-endian.
- Sits between the fetcher/LSB and the top-level RAM bus (mem_din/mem_dout/mem_a/mem_wr).
- Arbitrates with alternating priority, stalls IO writes while the IO buffer is full, and aborts fetches on pipeline clear.

---
 rtl/mem_arbiter.sv | 217 +++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Byte-serial arbiter sharing one RAM/IO port between the instruction fetcher and the LSB.
// Splits 1/2/4-byte accesses into byte transfers and assembles read data little-endian.
module mem_arbiter #(
    parameter logic [1:0] IO_SEL = 2'b11
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        io_buffer_full,
    input  logic        clr_in,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_done,
    output logic [31:0] if_data,
    input  logic        lsb_req,
    input  logic        lsb_we,
    input  logic [1:0]  lsb_size,
    input  logic [31:0] lsb_addr,
    input  logic [31:0] lsb_wdata,
    output logic        lsb_done,
    output logic [31:0] lsb_rdata
);
    typedef enum logic [1:0] {S_IDLE, S_RD, S_WR} state_t;
    typedef enum logic {G_IF, G_LSB} grant_t;

    state_t      r_state, w_state;
    grant_t      r_last, w_last, r_owner, w_owner;
    logic [31:0] r_addr, w_addr, r_wdata, w_wdata, r_buf, w_buf;
    logic [2:0]  r_n, w_n, r_issue, w_issue, r_cap, w_cap;
    logic        r_io, w_io, r_present, w_present, r_dvalid, w_dvalid;
    logic [31:0] r_mem_a, w_mem_a, r_if_data, w_if_data, r_lsb_rdata, w_lsb_rdata;
    logic [7:0]  r_mem_dout, w_mem_dout, r_held;
    logic        r_mem_wr, w_mem_wr, r_if_done, w_if_done, r_lsb_done, w_lsb_done, r_held_v;
    logic        w_if_el, w_lsb_el, w_pick_lsb;
    logic [2:0]  w_lsb_n;
    logic [7:0]  w_rbyte;

    assign w_lsb_n    = (lsb_size == 2'd0) ? 3'd1 : (lsb_size == 2'd1) ? 3'd2 : 3'd4;
    assign w_if_el    = if_req & ~r_if_done & ~clr_in;
    assign w_lsb_el   = lsb_req & ~r_lsb_done;
    assign w_pick_lsb = w_lsb_el & (~w_if_el | (r_last == G_IF));
    // After a freeze mem_din already reflects the held mem_a, so the byte pending at the freeze is replayed
    assign w_rbyte    = r_held_v ? r_held : mem_din;

    always_comb begin
        w_state     = r_state;
        w_last      = r_last;
        w_owner     = r_owner;
        w_addr      = r_addr;
        w_wdata     = r_wdata;
        w_buf       = r_buf;
        w_n         = r_n;
        w_issue     = r_issue;
        w_cap       = r_cap;
        w_io        = r_io;
        w_present   = r_present;
        w_dvalid    = r_dvalid;
        w_mem_a     = r_mem_a;
        w_mem_dout  = r_mem_dout;
        w_mem_wr    = 1'b0;
        w_if_done   = 1'b0;
        w_lsb_done  = 1'b0;
        w_if_data   = r_if_data;
        w_lsb_rdata = r_lsb_rdata;
        case (r_state)
            S_IDLE: begin
                if (w_pick_lsb) begin
                    w_owner   = G_LSB;
                    w_last    = G_LSB;
                    w_addr    = lsb_addr;
                    w_wdata   = lsb_wdata;
                    w_n       = w_lsb_n;
                    w_io      = (lsb_addr[17:16] == IO_SEL);
                    w_buf     = '0;
                    w_cap     = '0;
                    w_dvalid  = 1'b0;
                    w_present = 1'b1;
                    w_mem_a   = lsb_addr;
                    w_issue   = 3'd1;
                    if (lsb_we) begin
                        w_state = S_WR;
                        if (w_io && io_buffer_full) begin
                            w_issue = '0;
                        end else begin
                            w_mem_dout = lsb_wdata[7:0];
                            w_mem_wr   = 1'b1;
                        end
                    end else begin
                        w_state = S_RD;
                    end
                end else if (w_if_el) begin
                    w_owner   = G_IF;
                    w_last    = G_IF;
                    w_addr    = if_addr;
                    w_n       = 3'd4;
                    w_io      = 1'b0;
                    w_buf     = '0;
                    w_cap     = '0;
                    w_dvalid  = 1'b0;
                    w_present = 1'b1;
                    w_mem_a   = if_addr;
                    w_issue   = 3'd1;
                    w_state   = S_RD;
                end
            end
            S_RD: begin
                if (r_owner == G_IF && clr_in) begin
                    w_state = S_IDLE;
                end else begin
                    // Data for the address presented this cycle arrives next cycle
                    w_dvalid  = r_present;
                    w_present = (r_issue < r_n);
                    if (r_issue < r_n) begin
                        w_mem_a = r_addr + {29'd0, r_issue};
                        w_issue = r_issue + 3'd1;
                    end
                    if (r_dvalid) begin
                        w_buf[{r_cap[1:0], 3'b000} +: 8] = w_rbyte;
                        w_cap = r_cap + 3'd1;
                        if (r_cap == r_n - 3'd1) begin
                            w_state = S_IDLE;
                            if (r_owner == G_IF) begin
                                w_if_done = 1'b1;
                                w_if_data = w_buf;
                            end else begin
                                w_lsb_done  = 1'b1;
                                w_lsb_rdata = w_buf;
                            end
                        end
                    end
                end
            end
            S_WR: begin
                if (r_issue == r_n) begin
                    w_state    = S_IDLE;
                    w_lsb_done = 1'b1;
                end else if (!(r_io && io_buffer_full)) begin
                    w_mem_a    = r_addr + {29'd0, r_issue};
                    w_mem_dout = r_wdata[{r_issue[1:0], 3'b000} +: 8];
                    w_mem_wr   = 1'b1;
                    w_issue    = r_issue + 3'd1;
                end
            end
            default: w_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state     <= S_IDLE;
            r_last      <= G_IF;
            r_owner     <= G_IF;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_buf       <= '0;
            r_n         <= '0;
            r_issue     <= '0;
            r_cap       <= '0;
            r_io        <= 1'b0;
            r_present   <= 1'b0;
            r_dvalid    <= 1'b0;
            r_mem_a     <= '0;
            r_mem_dout  <= '0;
            r_mem_wr    <= 1'b0;
            r_if_done   <= 1'b0;
            r_lsb_done  <= 1'b0;
            r_if_data   <= '0;
            r_lsb_rdata <= '0;
        end else if (rdy_in) begin
            r_state     <= w_state;
            r_last      <= w_last;
            r_owner     <= w_owner;
            r_addr      <= w_addr;
            r_wdata     <= w_wdata;
            r_buf       <= w_buf;
            r_n         <= w_n;
            r_issue     <= w_issue;
            r_cap       <= w_cap;
            r_io        <= w_io;
            r_present   <= w_present;
            r_dvalid    <= w_dvalid;
            r_mem_a     <= w_mem_a;
            r_mem_dout  <= w_mem_dout;
            r_mem_wr    <= w_mem_wr;
            r_if_done   <= w_if_done;
            r_lsb_done  <= w_lsb_done;
            r_if_data   <= w_if_data;
            r_lsb_rdata <= w_lsb_rdata;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_held   <= '0;
            r_held_v <= 1'b0;
        end else if (!rdy_in) begin
            if (!r_held_v) begin
                r_held   <= mem_din;
                r_held_v <= 1'b1;
            end
        end else begin
            r_held_v <= 1'b0;
        end
    end

    assign mem_a     = r_mem_a;
    assign mem_dout  = r_mem_dout;
    assign mem_wr    = r_mem_wr & rdy_in;
    assign if_done   = r_if_done;
    assign if_data   = r_if_data;
    assign lsb_done  = r_lsb_done;
    assign lsb_rdata = r_lsb_rdata;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: table of single-requester transfers plus hand sequences for
// arbitration ties, IO stalls, pipeline clear, freezes and reset, against a synchronous RAM model.
module tb_mem_arbiter;
    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, io_buffer_full, clr_in;
    logic [7:0]  mem_din, mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        if_req, if_done;
    logic [31:0] if_addr, if_data;
    logic        lsb_req, lsb_we, lsb_done;
    logic [1:0]  lsb_size;
    logic [31:0] lsb_addr, lsb_wdata, lsb_rdata;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int n_if_done = 0;
    int n_lsb_done = 0;

    mem_arbiter #(.IO_SEL(2'b11)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .io_buffer_full(io_buffer_full),
        .clr_in(clr_in), .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
        .lsb_req(lsb_req), .lsb_we(lsb_we), .lsb_size(lsb_size), .lsb_addr(lsb_addr),
        .lsb_wdata(lsb_wdata), .lsb_done(lsb_done), .lsb_rdata(lsb_rdata)
    );

    always #5 clk_in = ~clk_in;

    // Synchronous RAM model: unwritten locations return a fixed preload pattern.
    bit [7:0] ram [0:262143];
    bit       wflag [0:262143];

    function automatic logic [7:0] init_byte(input logic [17:0] a);
        case (a)
            18'h00100: return 8'h13;
            18'h00101: return 8'h05;
            18'h00102: return 8'h10;
            18'h00103: return 8'h00;
            18'h00010: return 8'h11;
            18'h00011: return 8'h22;
            18'h00012: return 8'h33;
            18'h00013: return 8'h44;
            18'h00040: return 8'hCD;
            18'h00041: return 8'hAB;
            18'h3FFFF: return 8'h5A;
            18'h00000: return 8'hA5;
            default:   return 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        return wflag[a[17:0]] ? ram[a[17:0]] : init_byte(a[17:0]);
    endfunction

    function automatic logic [7:0] wbyte(input logic [31:0] w, input int k);
        return 8'(w >> (8 * k));
    endfunction

    always @(posedge clk_in) begin
        if (mem_wr) begin
            ram[mem_a[17:0]]   <= mem_dout;
            wflag[mem_a[17:0]] <= 1'b1;
        end
        mem_din <= mem_byte(mem_a);
    end

    always @(negedge clk_in) begin
        if (if_done === 1'b1) n_if_done++;
        if (lsb_done === 1'b1) n_lsb_done++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick;
        @(posedge clk_in);
        #1;
        cyc++;
    endtask

    task automatic do_reset;
        if_req = 1'b0; if_addr = '0;
        lsb_req = 1'b0; lsb_we = 1'b0; lsb_size = 2'd0; lsb_addr = '0; lsb_wdata = '0;
        clr_in = 1'b0; io_buffer_full = 1'b0; rdy_in = 1'b1;
        rst_in = 1'b1;
        tick;
        tick;
        rst_in = 1'b0;
    endtask

    task automatic lsb_go(input logic we, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
        lsb_req = 1'b1; lsb_we = we; lsb_size = sz; lsb_addr = a; lsb_wdata = wd;
    endtask

    // Ticks until the selected done pulse; returns its cycle relative to t0, or -1 on timeout.
    task automatic wait_done(input bit is_if, input int t0, output int rel);
        rel = -1;
        for (int i = 0; i < 40 && rel < 0; i++) begin
            tick;
            if ((is_if ? if_done : lsb_done) === 1'b1) begin
                rel = cyc - t0;
                if (is_if) if_req = 1'b0;
                else lsb_req = 1'b0;
            end
        end
    endtask

    typedef struct {
        logic        is_if;
        logic        we;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        iofull;
        logic [31:0] exp_data;
        int          exp_cyc;
    } vec_t;

    vec_t vecs[10];

    task automatic run_vec(input vec_t v, input int idx);
        int          n, done_cyc, pulses, bus_err, stray;
        logic [31:0] got, ea;
        logic        d, od;
        n = v.is_if ? 4 : (v.size == 2'd0 ? 1 : (v.size == 2'd1 ? 2 : 4));
        done_cyc = -1; pulses = 0; bus_err = 0; stray = 0; got = '0;
        io_buffer_full = v.iofull;
        if (v.is_if) begin
            if_req = 1'b1; if_addr = v.addr;
        end else begin
            lsb_go(v.we, v.size, v.addr, v.wdata);
        end
        for (int c = 1; c <= 14; c++) begin
            tick;
            if (c <= n) begin
                ea = v.addr + 32'(c - 1);
                if (mem_a !== ea) bus_err++;
                if (v.we) begin
                    if (mem_wr !== 1'b1 || mem_dout !== wbyte(v.wdata, c - 1)) bus_err++;
                end else if (mem_wr !== 1'b0) begin
                    bus_err++;
                end
            end else if (mem_wr !== 1'b0) begin
                bus_err++;
            end
            d  = v.is_if ? if_done : lsb_done;
            od = v.is_if ? lsb_done : if_done;
            if (od === 1'b1) stray++;
            if (d === 1'b1) begin
                pulses++;
                if (done_cyc < 0) begin
                    done_cyc = c;
                    got = v.is_if ? if_data : lsb_rdata;
                end
                if_req = 1'b0;
                lsb_req = 1'b0;
            end
        end
        io_buffer_full = 1'b0;
        chk($sformatf("v%0d_done_cycle", idx), 32'(done_cyc), 32'(v.exp_cyc));
        chk($sformatf("v%0d_done_pulses", idx), 32'(pulses), 32'd1);
        chk($sformatf("v%0d_bus_errors", idx), 32'(bus_err), 32'd0);
        chk($sformatf("v%0d_stray_done", idx), 32'(stray), 32'd0);
        if (v.we) begin
            for (int k = 0; k < n; k++)
                chk($sformatf("v%0d_ram_byte%0d", idx, k), 32'(mem_byte(v.addr + 32'(k))), 32'(wbyte(v.wdata, k)));
        end else begin
            chk($sformatf("v%0d_rdata", idx), got, v.exp_data);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int          t0, r, base, wi;
        logic [7:0]  wr_pat;

        vecs[0] = '{1'b1, 1'b0, 2'd2, 32'h0000_0100, 32'h0,         1'b0, 32'h0010_0513, 6};
        vecs[1] = '{1'b0, 1'b0, 2'd0, 32'h0000_0010, 32'h0,         1'b0, 32'h0000_0011, 3};
        vecs[2] = '{1'b0, 1'b0, 2'd1, 32'h0000_0012, 32'h0,         1'b0, 32'h0000_4433, 4};
        vecs[3] = '{1'b0, 1'b0, 2'd3, 32'h0000_0010, 32'h0,         1'b0, 32'h4433_2211, 6};
        vecs[4] = '{1'b0, 1'b0, 2'd1, 32'hFFFF_FFFF, 32'h0,         1'b0, 32'h0000_A55A, 4};
        vecs[5] = '{1'b0, 1'b1, 2'd1, 32'h0000_0050, 32'hDEADBEEF,  1'b0, 32'h0,         3};
        vecs[6] = '{1'b0, 1'b1, 2'd2, 32'h0000_0060, 32'h0BADF00D,  1'b1, 32'h0,         5};
        vecs[7] = '{1'b0, 1'b0, 2'd2, 32'h0000_0050, 32'h0,         1'b0, 32'h0000_BEEF, 6};
        vecs[8] = '{1'b0, 1'b0, 2'd2, 32'h0000_0060, 32'h0,         1'b0, 32'h0BAD_F00D, 6};
        vecs[9] = '{1'b0, 1'b1, 2'd0, 32'h0003_0010, 32'h0000_00E7, 1'b0, 32'h0,         2};

        // Reset state
        do_reset;
        chk("rst_mem_a", mem_a, 32'h0);
        chk("rst_mem_dout", 32'(mem_dout), 32'h0);
        chk("rst_mem_wr", 32'(mem_wr), 32'h0);
        chk("rst_if_done", 32'(if_done), 32'h0);
        chk("rst_lsb_done", 32'(lsb_done), 32'h0);
        chk("rst_if_data", if_data, 32'h0);
        chk("rst_lsb_rdata", lsb_rdata, 32'h0);

        // Tie after reset: LSB wins, then IF, then a second tie goes to LSB again
        t0 = cyc;
        if_req = 1'b1; if_addr = 32'h100;
        lsb_go(1'b1, 2'd0, 32'h200, 32'h0000_00AB);
        tick;
        chk("tie1_mem_wr", 32'(mem_wr), 32'h1);
        chk("tie1_mem_a", mem_a, 32'h200);
        chk("tie1_mem_dout", 32'(mem_dout), 32'hAB);
        wait_done(1'b0, t0, r);
        chk("tie1_lsb_done_cycle", 32'(r), 32'd2);
        wait_done(1'b1, t0, r);
        chk("tie1_if_done_cycle", 32'(r), 32'd8);
        chk("tie1_if_data", if_data, 32'h0010_0513);
        tick;
        t0 = cyc;
        if_req = 1'b1; if_addr = 32'h100;
        lsb_go(1'b0, 2'd0, 32'h10, 32'h0);
        tick;
        chk("tie2_mem_a_lsb_first", mem_a, 32'h10);
        wait_done(1'b0, t0, r);
        chk("tie2_lsb_done_cycle", 32'(r), 32'd3);
        chk("tie2_lsb_rdata", lsb_rdata, 32'h11);
        wait_done(1'b1, t0, r);
        chk("tie2_if_done_cycle", 32'(r), 32'd9);

        // IO store stalled by a full IO buffer in cycles 2-4
        tick;
        t0 = cyc;
        wr_pat = 8'b0110_0011;
        wi = 0;
        lsb_go(1'b1, 2'd2, 32'h0003_0000, 32'h1234_5678);
        for (int c = 1; c <= 8; c++) begin
            tick;
            if (c == 2) io_buffer_full = 1'b1;
            if (c == 5) io_buffer_full = 1'b0;
            chk($sformatf("io_c%0d_mem_wr", c), 32'(mem_wr), 32'(wr_pat[c-1]));
            if (wr_pat[c-1]) begin
                chk($sformatf("io_c%0d_mem_a", c), mem_a, 32'h0003_0000 + 32'(wi));
                chk($sformatf("io_c%0d_mem_dout", c), 32'(mem_dout), 32'(wbyte(32'h1234_5678, wi)));
                wi++;
            end
            chk($sformatf("io_c%0d_lsb_done", c), 32'(lsb_done), 32'(c == 8));
            if (lsb_done === 1'b1) lsb_req = 1'b0;
        end
        lsb_req = 1'b0;
        io_buffer_full = 1'b0;

        // Pipeline clear in cycle 3 of a fetch while the LSB waits
        tick;
        base = n_if_done;
        t0 = cyc;
        if_req = 1'b1; if_addr = 32'h100;
        tick;
        lsb_go(1'b0, 2'd0, 32'h12, 32'h0);
        tick;
        tick;
        clr_in = 1'b1; if_req = 1'b0;
        tick;
        clr_in = 1'b0;
        tick;
        chk("clr_lsb_granted_mem_a", mem_a, 32'h12);
        chk("clr_mem_wr", 32'(mem_wr), 32'h0);
        wait_done(1'b0, t0, r);
        chk("clr_lsb_done_cycle", 32'(r), 32'd7);
        chk("clr_lsb_rdata", lsb_rdata, 32'h33);
        repeat (4) tick;
        chk("clr_no_if_done", 32'(n_if_done - base), 32'd0);
        chk("clr_if_data_held", if_data, 32'h0010_0513);

        // Freeze for 3 cycles in the middle of a 2-byte load
        t0 = cyc;
        lsb_go(1'b0, 2'd1, 32'h40, 32'h0);
        tick;
        tick;
        rdy_in = 1'b0;
        tick;
        tick;
        chk("frz_mem_a_held", mem_a, 32'h41);
        chk("frz_mem_wr", 32'(mem_wr), 32'h0);
        tick;
        rdy_in = 1'b1;
        wait_done(1'b0, t0, r);
        chk("frz_lsb_done_cycle", 32'(r), 32'd7);
        chk("frz_lsb_rdata", lsb_rdata, 32'h0000_ABCD);

        // Freeze while a store byte is on the bus: the write is suppressed until rdy returns
        tick;
        t0 = cyc;
        lsb_go(1'b1, 2'd0, 32'h80, 32'h0000_005C);
        tick;
        rdy_in = 1'b0;
        #1;
        chk("frzw_mem_wr_forced", 32'(mem_wr), 32'h0);
        tick;
        chk("frzw_mem_wr_still", 32'(mem_wr), 32'h0);
        rdy_in = 1'b1;
        #1;
        chk("frzw_mem_wr_resume", 32'(mem_wr), 32'h1);
        chk("frzw_mem_dout", 32'(mem_dout), 32'h5C);
        wait_done(1'b0, t0, r);
        chk("frzw_lsb_done_cycle", 32'(r), 32'd3);
        chk("frzw_ram", 32'(mem_byte(32'h80)), 32'h5C);

        // Reset in the middle of a 4-byte store, then a fresh load
        tick;
        lsb_go(1'b1, 2'd2, 32'h70, 32'hCAFE_F00D);
        tick;
        tick;
        rst_in = 1'b1;
        lsb_req = 1'b0;
        base = n_lsb_done;
        tick;
        rst_in = 1'b0;
        chk("mrst_mem_a", mem_a, 32'h0);
        chk("mrst_mem_dout", 32'(mem_dout), 32'h0);
        chk("mrst_mem_wr", 32'(mem_wr), 32'h0);
        chk("mrst_lsb_done", 32'(lsb_done), 32'h0);
        chk("mrst_if_data", if_data, 32'h0);
        chk("mrst_lsb_rdata", lsb_rdata, 32'h0);
        repeat (4) tick;
        chk("mrst_no_done", 32'(n_lsb_done - base), 32'd0);
        chk("mrst_ram70", 32'(mem_byte(32'h70)), 32'h0D);
        chk("mrst_ram71", 32'(mem_byte(32'h71)), 32'hF0);
        chk("mrst_ram72", 32'(mem_byte(32'h72)), 32'h00);
        t0 = cyc;
        lsb_go(1'b0, 2'd1, 32'h70, 32'h0);
        wait_done(1'b0, t0, r);
        chk("mrst_fresh_done_cycle", 32'(r), 32'd4);
        chk("mrst_fresh_rdata", lsb_rdata, 32'h0000_F00D);

        // Table of single-requester transfers
        for (int i = 0; i < 10; i++) begin
            tick;
            run_vec(vecs[i], i);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
